// File: rtl/peak_rank_sequencer_pkg.sv
// peak_rank_sequencer_pkg: FSM encoding, signed rail constants and peak-slice helper.
package peak_rank_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        STORE,
        NEXT,
        FINISH
    } state_t;

    // Rails are returned in 64 bits; callers keep the low dw bits.
    function automatic logic [63:0] max_pos(int dw);
        return (64'd1 << (dw - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] min_neg(int dw);
        return 64'd1 << (dw - 1);
    endfunction

    function automatic int slice_lo(int idx, int dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/peak_rank_sequencer_limit_step.sv
// peak_rank_sequencer_limit_step: saturating val - GUARD with underflow flag.
module peak_rank_sequencer_limit_step
    import peak_rank_sequencer_pkg::*;
#(
    parameter int W     = 18,
    parameter int GUARD = 16
) (
    input  logic [W-1:0] val,
    output logic [W-1:0] res,
    output logic         underflow
);

    localparam logic [63:0] MN64 = min_neg(W);
    localparam logic [W-1:0] MINNEG = MN64[W-1:0];
    localparam logic signed [W:0] FLOOR = $signed({1'b1, MINNEG}) + (W+1)'(1);

    logic signed [W:0] diff;

    // One extra bit so the subtraction never wraps before the floor test.
    assign diff      = $signed({val[W-1], val}) - $signed((W+1)'(GUARD));
    assign underflow = diff < FLOOR;
    assign res       = underflow ? MINNEG : diff[W-1:0];

endmodule

// File: rtl/peak_rank_sequencer.sv
// peak_rank_sequencer: ranks the NUM_PEAKS largest distinct values via repeated limited-max passes.
// Optional macro PEAK_SEQ_AUTO_EN: self-trigger a new run AUTO_GAP idle cycles after each run.
module peak_rank_sequencer
    import peak_rank_sequencer_pkg::*;
#(
    parameter int          DATA_WIDTH  = 18,
    parameter int          NUM_PEAKS   = 4,
    parameter int          GUARD       = 16,
    parameter logic [31:0] TIMEOUT_CNT = 32'd8192,
    parameter int          TO_WIDTH    = 32,
    parameter logic [31:0] AUTO_GAP    = 32'd1000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            trig,
    output logic                            fnd_start,
    output logic [DATA_WIDTH-1:0]           fnd_limit,
    input  logic [DATA_WIDTH-1:0]           fnd_max,
    input  logic                            fnd_dready,
    output logic [NUM_PEAKS*DATA_WIDTH-1:0] peaks,
    output logic [3:0]                      peak_cnt,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout
);

    localparam logic [63:0] MP64 = max_pos(DATA_WIDTH);
    localparam logic [63:0] MN64 = min_neg(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MAXPOS = MP64[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] MINNEG = MN64[DATA_WIDTH-1:0];
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CNT - 32'd1);

    state_t                state, nxt;
    logic [2:0]            pass;
    logic [3:0]            found;
    logic [DATA_WIDTH-1:0] cap;
    logic [DATA_WIDTH-1:0] work [NUM_PEAKS];
    logic [DATA_WIDTH-1:0] step_res;
    logic                  step_uf;
    logic                  last;
    logic [TO_WIDTH-1:0]   to_cnt;
    logic                  go;

    peak_rank_sequencer_limit_step #(
        .W    (DATA_WIDTH),
        .GUARD(GUARD)
    ) u_limit_step (
        .val      (cap),
        .res      (step_res),
        .underflow(step_uf)
    );

    assign last = pass == 3'(NUM_PEAKS - 1);

`ifdef PEAK_SEQ_AUTO_EN
    logic                gap_act;
    logic [TO_WIDTH-1:0] gap_cnt;

    assign go = trig || (gap_act && gap_cnt == TO_WIDTH'(AUTO_GAP - 32'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_act <= 1'b0;
            gap_cnt <= '0;
        end else if (state == FINISH) begin
            gap_act <= 1'b1;
            gap_cnt <= '0;
        end else if (state == IDLE) begin
            if (go)
                gap_act <= 1'b0;
            else if (gap_act)
                gap_cnt <= gap_cnt + 1'b1;
        end
    end
`else
    logic unused_auto_gap;

    assign go              = trig;
    assign unused_auto_gap = ^AUTO_GAP;
`endif

    always_comb begin
        nxt       = state;
        fnd_start = state == START;
        busy      = state == START || state == WAIT || state == STORE || state == NEXT;
        done      = state == FINISH;
        case (state)
            IDLE:    nxt = go ? START : IDLE;
            START:   nxt = WAIT;
            WAIT:    nxt = fnd_dready ? STORE : (to_cnt == TO_LAST ? FINISH : WAIT);
            STORE:   nxt = cap == MINNEG ? FINISH : NEXT;
            NEXT:    nxt = (last || step_uf) ? FINISH : START;
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pass      <= '0;
            found     <= '0;
            cap       <= MINNEG;
            to_cnt    <= '0;
            fnd_limit <= MAXPOS;
            timeout   <= 1'b0;
            peak_cnt  <= '0;
            peaks     <= {NUM_PEAKS{MINNEG}};
            for (int i = 0; i < NUM_PEAKS; i++)
                work[i] <= MINNEG;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (go) begin
                    pass      <= '0;
                    found     <= '0;
                    fnd_limit <= MAXPOS;
                    timeout   <= 1'b0;
                    for (int i = 0; i < NUM_PEAKS; i++)
                        work[i] <= MINNEG;
                end
                START: to_cnt <= '0;
                WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (fnd_dready)
                        cap <= fnd_max;
                    else if (to_cnt == TO_LAST)
                        timeout <= 1'b1;
                end
                STORE: if (cap != MINNEG) begin
                    found <= found + 4'd1;
                    for (int i = 0; i < NUM_PEAKS; i++)
                        if (pass == 3'(i))
                            work[i] <= cap;
                end
                NEXT: if (!last && !step_uf) begin
                    fnd_limit <= step_res;
                    pass      <= pass + 3'd1;
                end
                default: ;
            endcase
            // Results land on the edge into FINISH so they are valid while done is high.
            if (nxt == FINISH && state != FINISH) begin
                peak_cnt <= found;
                for (int i = 0; i < NUM_PEAKS; i++)
                    peaks[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] <= work[i];
            end
        end
    end

endmodule

// File: tb/tb_peak_rank_sequencer.sv
// tb_peak_rank_sequencer: directed checks of peak_rank_sequencer against a behavioural max-finder.
module tb_peak_rank_sequencer;

    localparam int DW     = 18;
    localparam int NP     = 4;
    localparam int MAXPOS = 131071;
    localparam int MINNEG = -131072;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              trig = 1'b0;
    logic              fnd_start;
    logic [DW-1:0]     fnd_limit;
    logic [DW-1:0]     fnd_max = '0;
    logic              fnd_dready = 1'b0;
    logic [NP*DW-1:0]  peaks;
    logic [3:0]        peak_cnt;
    logic              busy;
    logic              done;
    logic              timeout;

    int            tests = 0;
    int            fails = 0;
    int            data[$];
    int            lims[$];
    bit            hang = 1'b0;
    int            cd = 0;
    logic [DW-1:0] fres = '0;
    int            starts = 0;
    int            dones = 0;
    int            cyc = 0;

    always #5 clk = ~clk;

    peak_rank_sequencer #(
        .DATA_WIDTH (DW),
        .NUM_PEAKS  (NP),
        .GUARD      (16),
        .TIMEOUT_CNT(32'd8192),
        .TO_WIDTH   (32),
        .AUTO_GAP   (32'd1000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig      (trig),
        .fnd_start (fnd_start),
        .fnd_limit (fnd_limit),
        .fnd_max   (fnd_max),
        .fnd_dready(fnd_dready),
        .peaks     (peaks),
        .peak_cnt  (peak_cnt),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    function automatic logic [DW-1:0] best(int lim);
        int b = MINNEG;
        foreach (data[i])
            if (data[i] <= lim && data[i] > b)
                b = data[i];
        return DW'(b);
    endfunction

    // Finder model: answers 3 cycles after start unless hang is set.
    always @(posedge clk) begin
        fnd_dready <= 1'b0;
        cyc <= cyc + 1;
        if (done)
            dones <= dones + 1;
        if (fnd_start) begin
            starts <= starts + 1;
            lims.push_back($signed(fnd_limit));
            fres <= best($signed(fnd_limit));
            cd <= 3;
        end else if (cd != 0) begin
            cd <= cd - 1;
            if (cd == 1 && !hang) begin
                fnd_dready <= 1'b1;
                fnd_max <= fres;
            end
        end
    end

    function automatic logic [127:0] pk(int r0, int r1, int r2, int r3);
        logic [NP*DW-1:0] v;
        v = {DW'(r3), DW'(r2), DW'(r1), DW'(r0)};
        return 128'(v);
    endfunction

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fire();
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_done(int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            ok = done;
        end
        check("done_seen", 128'(ok), 128'(1));
    endtask

    function automatic int lim_at(int i);
        return i < lims.size() ? lims[i] : 12345;
    endfunction

    initial begin
        int s0, d0, c0;
        int e1[4] = '{MAXPOS, 984, 784, 484};

        repeat (2) @(negedge clk);
        check("rst_start", 128'(fnd_start), 128'(0));
        check("rst_limit", 128'(fnd_limit), 128'(18'h1FFFF));
        check("rst_peaks", 128'(peaks), pk(MINNEG, MINNEG, MINNEG, MINNEG));
        check("rst_cnt", 128'(peak_cnt), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_timeout", 128'(timeout), 128'(0));
        rst_n = 1'b1;

        // Four distinct maxima with a duplicate.
        data = '{1000, 800, 1000, 500, 100};
        lims.delete();
        s0 = starts;
        d0 = dones;
        fire();
        check("t1_busy", 128'(busy), 128'(1));
        wait_done(300);
        check("t1_peaks", 128'(peaks), pk(1000, 800, 500, 100));
        check("t1_cnt", 128'(peak_cnt), 128'(4));
        check("t1_timeout", 128'(timeout), 128'(0));
        check("t1_busy_done", 128'(busy), 128'(0));
        for (int i = 0; i < 4; i++)
            check("t1_limit", 128'(lim_at(i)), 128'(e1[i]));
        repeat (5) @(negedge clk);
        check("t1_starts", 128'(starts - s0), 128'(4));
        check("t1_dones", 128'(dones - d0), 128'(1));

        // Second peak within GUARD of the first: pass 1 finds nothing.
        data = '{1000, 990};
        lims.delete();
        s0 = starts;
        fire();
        wait_done(300);
        check("t2_peaks", 128'(peaks), pk(1000, MINNEG, MINNEG, MINNEG));
        check("t2_cnt", 128'(peak_cnt), 128'(1));
        check("t2_limit1", 128'(lim_at(1)), 128'(984));
        repeat (2) @(negedge clk);
        check("t2_starts", 128'(starts - s0), 128'(2));

        // Finder never answers.
        hang = 1'b1;
        data = '{500};
        s0 = starts;
        fire();
        c0 = cyc;
        wait_done(9000);
        check("t3_timeout", 128'(timeout), 128'(1));
        check("t3_wait_len", 128'(cyc - c0), 128'(8193));
        check("t3_cnt", 128'(peak_cnt), 128'(0));
        check("t3_peaks", 128'(peaks), pk(MINNEG, MINNEG, MINNEG, MINNEG));
        repeat (2) @(negedge clk);
        check("t3_starts", 128'(starts - s0), 128'(1));
        check("t3_sticky", 128'(timeout), 128'(1));
        hang = 1'b0;

        // Peak near the negative rail: next limit would underflow.
        data = '{-131060};
        lims.delete();
        s0 = starts;
        fire();
        check("t4_to_clear", 128'(timeout), 128'(0));
        wait_done(300);
        check("t4_cnt", 128'(peak_cnt), 128'(1));
        check("t4_peaks", 128'(peaks), pk(-131060, MINNEG, MINNEG, MINNEG));
        check("t4_limit_hold", 128'(fnd_limit), 128'(18'h1FFFF));
        repeat (10) @(negedge clk);
        check("t4_starts", 128'(starts - s0), 128'(1));

        // Next limit lands exactly on MINNEG+1: allowed, one more pass.
        data = '{-131055};
        lims.delete();
        s0 = starts;
        fire();
        wait_done(300);
        check("t4b_cnt", 128'(peak_cnt), 128'(1));
        check("t4b_limit1", 128'(lim_at(1)), 128'(-131071));
        repeat (2) @(negedge clk);
        check("t4b_starts", 128'(starts - s0), 128'(2));

        // trig storm while busy and on the done cycle.
        data = '{1000, 800, 500, 100};
        s0 = starts;
        d0 = dones;
        fire();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                trig = 1'b1;
                @(negedge clk);
                trig = 1'b0;
                break;
            end
            trig = (i % 3 == 0);
        end
        trig = 1'b0;
        repeat (30) @(negedge clk);
        check("t5_starts", 128'(starts - s0), 128'(4));
        check("t5_dones", 128'(dones - d0), 128'(1));
        check("t5_busy", 128'(busy), 128'(0));
        check("t5_cnt", 128'(peak_cnt), 128'(4));

        // Reset in the middle of WAIT.
        hang = 1'b1;
        fire();
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_start", 128'(fnd_start), 128'(0));
        check("t6_limit", 128'(fnd_limit), 128'(18'h1FFFF));
        check("t6_peaks", 128'(peaks), pk(MINNEG, MINNEG, MINNEG, MINNEG));
        check("t6_cnt", 128'(peak_cnt), 128'(0));
        check("t6_busy", 128'(busy), 128'(0));
        check("t6_done", 128'(done), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s0 = starts;
        repeat (50) @(negedge clk);
        check("t6_no_start", 128'(starts - s0), 128'(0));
        hang = 1'b0;

`ifdef PEAK_SEQ_AUTO_EN
        data = '{1000, 800, 500, 100};
        fire();
        wait_done(300);
        c0 = cyc;
        for (int i = 0; i < 1200 && !fnd_start; i++)
            @(negedge clk);
        check("t7_auto_gap", 128'(cyc - c0), 128'(1001));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
